// File: rtl/song_player_seq_pkg.sv
// song_player_pkg: shared state encoding and clock constants for the song player
package song_player_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, PAUSED} state_e;
  localparam int DEFAULT_CLK_HZ = 50_000_000;
  localparam int UNIT_DIV_16 = DEFAULT_CLK_HZ / 16;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/song_player_seq_if.sv
// song_player_seq_if: control, note ROM and audio pin bundle of the song player
interface song_player_seq_if #(
  parameter int ADDR_W   = 5,
  parameter int PERIOD_W = 20,
  parameter int DUR_W    = 5
) ();
  logic                play_start;
  logic                play_stop;
  logic                pause;
  logic                loop_en;
  logic [ADDR_W-1:0]   note_addr;
  logic [PERIOD_W-1:0] note_period;
  logic [DUR_W-1:0]    note_dur;
  logic                note_last;
  logic                audioOut;
  logic                aud_sd;
  logic                busy;
  logic                done;
  modport slave (
    input  play_start, play_stop, pause, loop_en, note_period, note_dur, note_last,
    output note_addr, audioOut, aud_sd, busy, done
  );
  modport master (
    output play_start, play_stop, pause, loop_en, note_period, note_dur, note_last,
    input  note_addr, audioOut, aud_sd, busy, done
  );
endinterface

// File: rtl/song_player_seq_tone_divider.sv
// tone_divider: half-period counter producing a square wave, silent for period 0
module tone_divider #(
  parameter int PERIOD_W = 20
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en,
  input  logic                clr,
  input  logic [PERIOD_W-1:0] period,
  output logic                wave
);
  localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                wave_q, wave_d;
  logic                wrap;
  always_comb begin
    wrap   = cnt_q == period - ONE;
    cnt_d  = clr ? '0 : en ? (wrap ? '0 : cnt_q + ONE) : cnt_q;
    wave_d = clr ? 1'b1 : (en && wrap) ? ~wave_q : wave_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      wave_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wave_q <= wave_d;
    end
  end
  assign wave = wave_q & (|period);
endmodule

// File: rtl/song_player_seq.sv
// song_player_seq: steps a ROM note table and drives a square wave onto the audio pin
module song_player_seq
  import song_player_pkg::*;
#(
  parameter int CLK_HZ   = DEFAULT_CLK_HZ,
  parameter int TICK_DIV = CLK_HZ / 16,
  parameter int ADDR_W   = 5,
  parameter int PERIOD_W = 20,
  parameter int DUR_W    = 5
) (
  input logic              clock,
  input logic              reset,
  song_player_seq_if.slave bus
);
  localparam int TW = cnt_w(TICK_DIV);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic                last_q, last_d;
  logic [TW-1:0]       tick_q, tick_d;
  logic [DUR_W-1:0]    unit_q, unit_d;
  logic                done_q, done_d;
  logic                run, tick_wrap, note_end, end_last, wave;
  // A PLAY cycle with pause high is already frozen, so pause acts on the first PLAY cycle
  assign run       = state_q == PLAY && !bus.pause;
  assign tick_wrap = tick_q == TICK_MAX;
  assign note_end  = (state_q == LOAD && bus.note_dur == '0)
                   || (run && tick_wrap && unit_q == dur_q - 1'b1);
  assign end_last  = state_q == LOAD ? bus.note_last : last_q;
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    period_d = period_q;
    dur_d    = dur_q;
    last_d   = last_q;
    tick_d   = tick_q;
    unit_d   = unit_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE:   state_d = bus.play_start ? FETCH : IDLE;
      FETCH:  state_d = LOAD;
      LOAD: begin
        period_d = bus.note_period;
        dur_d    = bus.note_dur;
        last_d   = bus.note_last;
        tick_d   = '0;
        unit_d   = '0;
        state_d  = PLAY;
      end
      PLAY: begin
        state_d = bus.pause ? PAUSED : PLAY;
        tick_d  = run ? (tick_wrap ? '0 : tick_q + 1'b1) : tick_q;
        unit_d  = (run && tick_wrap) ? unit_q + 1'b1 : unit_q;
      end
      PAUSED: state_d = bus.pause ? PAUSED : PLAY;
      default: state_d = IDLE;
    endcase
    if (note_end) begin
      tick_d  = '0;
      unit_d  = '0;
      state_d = (!end_last || bus.loop_en) ? FETCH : IDLE;
      addr_d  = end_last ? '0 : addr_q + 1'b1;
      done_d  = end_last && !bus.loop_en;
    end
    if (bus.play_stop) begin
      state_d = IDLE;
      addr_d  = '0;
      tick_d  = '0;
      unit_d  = '0;
      done_d  = 1'b0;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      period_q <= '0;
      dur_q    <= '0;
      last_q   <= 1'b0;
      tick_q   <= '0;
      unit_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      period_q <= period_d;
      dur_q    <= dur_d;
      last_q   <= last_d;
      tick_q   <= tick_d;
      unit_q   <= unit_d;
      done_q   <= done_d;
    end
  end
  tone_divider #(.PERIOD_W(PERIOD_W)) u_tone (
    .clock (clock),
    .reset (reset),
    .en    (run),
    .clr   (state_q == LOAD),
    .period(period_q),
    .wave  (wave)
  );
  assign bus.note_addr = addr_q;
  assign bus.audioOut  = run & wave;
  assign bus.aud_sd    = state_q == FETCH || state_q == LOAD || run;
  assign bus.busy      = state_q != IDLE;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_song_player_seq.sv
// tb_song_player_seq: scoreboard bench replaying hand-computed per-cycle output traces
module tb_song_player_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int fails = 0;
  logic [25:0] rom [32];
  logic [8:0] exp_q [$];
  logic [8:0] got_w;
  logic [8:0] e;
  song_player_seq_if #(.ADDR_W(5), .PERIOD_W(20), .DUR_W(5)) bus ();
  song_player_seq #(.CLK_HZ(64), .TICK_DIV(4), .ADDR_W(5), .PERIOD_W(20), .DUR_W(5)) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  always_ff @(posedge clk) {bus.note_period, bus.note_dur, bus.note_last} <= rom[bus.note_addr];
  assign got_w = {bus.audioOut, bus.aud_sd, bus.busy, bus.done, bus.note_addr};
  always @(negedge clk) begin
    if (!rst && (bus.busy || bus.done)) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_activity got={aud,sd,busy,done,addr}=%b required=idle", got_w);
      end else begin
        e = exp_q.pop_front();
        if (got_w !== e) begin
          fails++;
          $display("FAIL trace t=%0t got={aud,sd,busy,done,addr}=%b required=%b", $time, got_w, e);
        end
      end
    end
  end
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic ex(input bit a, input bit s, input bit b, input bit d, input int addr, input int n = 1);
    for (int i = 0; i < n; i++) exp_q.push_back({a, s, b, d, 5'(addr)});
  endtask
  task automatic fetch_load(input int addr);
    ex(0, 1, 1, 0, addr, 2);
  endtask
  task automatic tone(input logic [15:0] pat, input int n, input int addr);
    for (int i = 0; i < n; i++) ex(pat[n-1-i], 1, 1, 0, addr);
  endtask
  task automatic rom_clear();
    for (int i = 0; i < 32; i++) rom[i] = '0;
  endtask
  task automatic rom_set(input int i, input int p, input int d, input bit l);
    rom[i] = {20'(p), 5'(d), l};
  endtask
  task automatic start();
    bus.play_start = 1'b1;
    step();
    bus.play_start = 1'b0;
  endtask
  task automatic drain(input string name, input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      step();
      n++;
    end
    step(3);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain got=%0d_pending required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic idle_check(input string name);
    @(negedge clk);
    checks++;
    if (got_w !== 9'b0) begin
      fails++;
      $display("FAIL %s_idle got=%b required=000000000", name, got_w);
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "timeout");
  end
  initial begin
    bus.play_start = 1'b0;
    bus.play_stop  = 1'b0;
    bus.pause      = 1'b0;
    bus.loop_en    = 1'b0;
    rom_clear();
    step(3);
    idle_check("reset");
    rst = 1'b0;
    step(2);
    // single note: 8 PLAY cycles of 11100011 then done on entry to IDLE
    rom_set(0, 3, 2, 1);
    fetch_load(0); tone(16'b11100011, 8, 0); ex(0, 0, 0, 1, 0);
    start();
    drain("single", 40);
    // rest then tone
    rom_clear(); rom_set(0, 0, 1, 0); rom_set(1, 2, 1, 1);
    fetch_load(0); tone(16'b0000, 4, 0); fetch_load(1); tone(16'b1100, 4, 1); ex(0, 0, 0, 1, 0);
    start();
    drain("rest", 40);
    // zero-length entry is skipped, first PLAY cycle at t+5
    rom_clear(); rom_set(0, 5, 0, 0); rom_set(1, 2, 1, 1);
    fetch_load(0); fetch_load(1); tone(16'b1100, 4, 1); ex(0, 0, 0, 1, 0);
    start();
    drain("skip", 40);
    // loop twice, drop loop_en during the third pass
    rom_clear(); rom_set(0, 2, 1, 0); rom_set(1, 3, 1, 1);
    for (int k = 0; k < 3; k++) begin
      fetch_load(0); tone(16'b1100, 4, 0); fetch_load(1); tone(16'b1110, 4, 1);
    end
    ex(0, 0, 0, 1, 0);
    bus.loop_en = 1'b1;
    start();
    step(25);
    bus.loop_en = 1'b0;
    drain("loop", 60);
    // pause over 10 cycles after the second PLAY cycle
    rom_clear(); rom_set(0, 3, 2, 1);
    fetch_load(0); tone(16'b11, 2, 0); ex(0, 0, 1, 0, 0, 11); tone(16'b100011, 6, 0); ex(0, 0, 0, 1, 0);
    start();
    step(4);
    bus.pause = 1'b1;
    step(10);
    bus.pause = 1'b0;
    drain("pause", 40);
    // stop during the second note with play_start held high
    rom_clear(); rom_set(0, 2, 1, 0); rom_set(1, 3, 2, 1);
    fetch_load(0); tone(16'b1100, 4, 0); fetch_load(1); tone(16'b1110, 4, 1);
    bus.play_start = 1'b1;
    step(12);
    bus.play_stop = 1'b1;
    step();
    bus.play_stop  = 1'b0;
    bus.play_start = 1'b0;
    idle_check("stop");
    drain("stop", 5);
    // stop wins over start in IDLE
    bus.play_start = 1'b1;
    bus.play_stop  = 1'b1;
    step();
    bus.play_start = 1'b0;
    bus.play_stop  = 1'b0;
    idle_check("priority");
    step(2);
    // address wraps 31 -> 0 without note_last
    rom_clear(); rom_set(0, 2, 1, 0);
    fetch_load(0); tone(16'b1100, 4, 0);
    for (int a = 1; a < 32; a++) fetch_load(a);
    fetch_load(0); tone(16'b1100, 4, 0); ex(0, 1, 1, 0, 1);
    start();
    step(74);
    bus.play_stop = 1'b1;
    step();
    bus.play_stop = 1'b0;
    idle_check("wrap");
    drain("wrap", 5);
    // reset mid-song
    rom_clear(); rom_set(0, 3, 2, 1);
    fetch_load(0); tone(16'b11, 2, 0);
    start();
    step(4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_check("midreset");
    drain("midreset", 5);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
